// File: rtl/domain_cross_pkg.sv
// Shared definitions for the time-shared level synchroniser scheduler:
// FSM encoding, default chain depth and a constant-friendly clog2.
package domain_cross_pkg;

  localparam int DEFAULT_DOMAIN_CROSS_REGS = 32'sd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } dcs_state_e;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 32'sd0;
    v      = (value > 32'sd1) ? (value - 32'sd1) : 32'sd0;
    while (v > 32'sd0) begin
      result = result + 32'sd1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/level_change_domain.sv
// Single-bit synchroniser chain of STAGES flops, shared by all requesters.
module level_change_domain #(
  parameter int STAGES = 3
) (
  input  logic SystemClk,
  input  logic SystemRst_n,
  input  logic chain_in,
  output logic chain_out
);

  logic [STAGES-1:0] stage_r;

  // Shift the level one stage per clock.
  always_ff @(posedge SystemClk or negedge SystemRst_n) begin
    if (!SystemRst_n) begin
      stage_r <= '0;
    end else begin
      stage_r[0] <= chain_in;
      for (int i = 1; i < STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign chain_out = stage_r[STAGES-1];

endmodule

// File: rtl/domain_cross_scheduler.sv
// Round-robin scheduler that time-shares one level_change_domain chain
// between NUM_REQ level signals, capturing each result into its own register.
module domain_cross_scheduler
  import domain_cross_pkg::*;
#(
  parameter int NUM_REQ                     = 4,
  parameter int number_of_domain_cross_regs = DEFAULT_DOMAIN_CROSS_REGS
) (
  input  logic               SystemClk,
  input  logic               SystemRst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] signal_in,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] signal_out,
  output logic               busy
);

  localparam int R  = number_of_domain_cross_regs;
  localparam int CW = clog2(R + 32'sd1);
  localparam int PW = (clog2(NUM_REQ) > 32'sd1) ? clog2(NUM_REQ) : 32'sd1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1'b1);

  dcs_state_e          state_r, state_nxt;
  logic [PW-1:0]       w_r, w_nxt;
  logic [PW-1:0]       ptr_r, ptr_nxt;
  logic [CW-1:0]       cnt_r, cnt_nxt;
  logic                load_r, load_nxt;
  logic [NUM_REQ-1:0]  grant_r, grant_nxt;
  logic [NUM_REQ-1:0]  done_r, done_nxt;
  logic [NUM_REQ-1:0]  sout_r, sout_nxt;
  logic                busy_r, busy_nxt;

  logic                found_s;
  logic [PW-1:0]       win_s;
  logic [NUM_REQ-1:0]  onehot_w_s;
  logic [NUM_REQ-1:0]  onehot_win_s;
  logic                chain_out_s;

  level_change_domain #(
    .STAGES (R)
  ) u_chain (
    .SystemClk   (SystemClk),
    .SystemRst_n (SystemRst_n),
    .chain_in    (load_r),
    .chain_out   (chain_out_s)
  );

  // Round-robin pick: first pass covers ptr..NUM_REQ-1, second pass wraps to 0..ptr-1.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found_s && req[j] && (j >= int'(ptr_r))) begin
        found_s = 1'b1;
        win_s   = PW'(j);
      end else begin
        found_s = found_s;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found_s && req[j]) begin
        found_s = 1'b1;
        win_s   = PW'(j);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign onehot_w_s   = ONE << w_r;
  assign onehot_win_s = ONE << win_s;

  // Next-state and next-output logic for the transfer sequence.
  always_comb begin
    state_nxt = state_r;
    w_nxt     = w_r;
    ptr_nxt   = ptr_r;
    cnt_nxt   = cnt_r;
    load_nxt  = load_r;
    grant_nxt = grant_r;
    done_nxt  = '0;
    sout_nxt  = sout_r;
    busy_nxt  = busy_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          w_nxt     = win_s;
          grant_nxt = onehot_win_s;
          busy_nxt  = 1'b1;
          state_nxt = ST_LOAD;
        end else begin
          grant_nxt = '0;
          busy_nxt  = 1'b0;
        end
      end
      ST_LOAD: begin
        load_nxt  = |(signal_in & onehot_w_s);
        cnt_nxt   = CW'(R);
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_nxt = cnt_r - CW'(1'b1);
        if (cnt_r == CW'(1'b1)) begin
          done_nxt  = onehot_w_s;
          state_nxt = ST_CAPTURE;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_CAPTURE: begin
        sout_nxt  = (sout_r & ~onehot_w_s) | (chain_out_s ? onehot_w_s : '0);
        ptr_nxt   = (w_r == PW'(NUM_REQ - 32'sd1)) ? '0 : (w_r + PW'(1'b1));
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: begin
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight transfer.
  always_ff @(posedge SystemClk or negedge SystemRst_n) begin
    if (!SystemRst_n) begin
      state_r <= ST_IDLE;
      w_r     <= '0;
      ptr_r   <= '0;
      cnt_r   <= '0;
      load_r  <= 1'b0;
      grant_r <= '0;
      done_r  <= '0;
      sout_r  <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      w_r     <= w_nxt;
      ptr_r   <= ptr_nxt;
      cnt_r   <= cnt_nxt;
      load_r  <= load_nxt;
      grant_r <= grant_nxt;
      done_r  <= done_nxt;
      sout_r  <= sout_nxt;
      busy_r  <= busy_nxt;
    end
  end

  assign grant      = grant_r;
  assign done       = done_r;
  assign signal_out = sout_r;
  assign busy       = busy_r;

endmodule

// File: doc/domain_cross_scheduler.md
# domain_cross_scheduler

Time-shares one `level_change_domain` synchroniser chain between `NUM_REQ` single-bit level signals. A round-robin arbiter grants one requester at a time and loads that requester's level into the chain. It waits for the level to traverse the chain, then captures the result into that requester's output register and pulses its `done`. The block sits between the per-signal input registers and downstream logic in the `SystemClk` domain, replacing one chain per signal.

## Interface
- `NUM_REQ`, default 4: number of requesters; range 1..16.
- `number_of_domain_cross_regs`, default 3: depth R of the shared chain; natural, at least 1.

- `SystemClk`  in  1: sole clock, rising edge.
- `SystemRst_n`  in  1: asynchronous, active-low reset.
- `req`  in  `NUM_REQ`: per-requester transfer request, level, held until `done`.
- `signal_in`  in  `NUM_REQ`: per-requester level to be transferred.
- `grant`  out  `NUM_REQ`: one-hot (or zero); identifies the requester currently owning the chain.
- `done`  out  `NUM_REQ`: one-cycle pulse when that requester's `signal_out` bit has been updated.
- `signal_out`  out  `NUM_REQ`: per-requester synchronised level, registered.
- `busy`  out  1: high whenever the FSM is not in IDLE.

## Operation
- Reset values:
  - `grant`, `done`, `signal_out`, `busy` are all 0.
  - FSM is in IDLE.
  - Round-robin pointer `ptr` = 0.
  - Wait counter = 0.
  - All chain stages = 0.
- FSM states:
  - IDLE
    - If no `req` bit is set: stay in IDLE.
    - Otherwise: the winner `w` is the first set `req` bit at or above `ptr`, wrapping modulo `NUM_REQ`.
    - Register `w`, then go to LOAD.
  - LOAD
    - Chain input register ← `signal_in[w]`. This is the only cycle in which `signal_in` is sampled.
    - Counter ← R.
    - Go to WAIT.
  - WAIT
    - Counter decrements once per cycle.
    - Go to CAPTURE when the counter reaches 1. WAIT therefore lasts exactly R cycles.
  - CAPTURE
    - `signal_out[w]` ← chain output.
    - `done[w]` = 1 for this cycle only.
    - `ptr` ← (w+1) mod `NUM_REQ`.
    - Go to IDLE.
- Output behaviour:
  - `grant[w]` is high in LOAD, WAIT and CAPTURE; `grant` is 0 in IDLE.
  - `signal_out` bits other than `w` hold their values.
- Widths:
  - Counter is clog2(R+1) bits.
  - `ptr` and `w` are max(1, clog2(`NUM_REQ`)) bits.
  - Wrap arithmetic is explicit modulo `NUM_REQ`; `NUM_REQ` need not be a power of 2.
- Boundary conditions:
  - **`req[w]` dropped mid-transfer:** the transfer still completes, `done[w]` still pulses and `signal_out[w]` is still updated. No abort path.
  - **`signal_in[w]` changes after LOAD:** ignored for this transfer.
  - **`req` asserted during a transfer:** waits. It is evaluated only in IDLE.
  - **All requests held continuously:** grants rotate 0,1,2,…,`NUM_REQ`-1,0. There is no starvation: worst-case wait is (`NUM_REQ`-1)·(R+3) cycles before own grant.
  - **`NUM_REQ` = 1:** requester 0 is always the winner; `ptr` stays 0.
  - **Reset mid-operation:** all state returns immediately to reset values. `signal_out` is cleared, no `done` is emitted and the in-flight transfer is lost.

## Timing
- Let E0 be the rising edge on which IDLE samples `req[w]`=1.
- LOAD is the cycle after E0; `grant[w]` and `busy` rise after E0.
- `done[w]` is high in the cycle following edge E0+R+1, i.e. the (R+2)-th cycle after E0.
- `signal_out[w]` shows the new value from edge E0+R+2 onward, coincident with the falling edge of `done`.
- IDLE lasts at least 1 cycle between transfers. Back-to-back transfer period is R+3 cycles.
- `busy` falls after the CAPTURE edge.

## Structure
- Shared package `domain_cross_pkg` holds:
  - FSM state encoding (IDLE, LOAD, WAIT, CAPTURE);
  - the clog2 function;
  - the default `number_of_domain_cross_regs` constant.
- Sub-module `level_change_domain`, instantiated once:
  - 1-bit, R-stage register chain;
  - chain input driven by the LOAD register;
  - reset by `SystemRst_n`.
- The arbiter/FSM stays in the top; there is no separate arbiter module.

## Test plan
- **Single request:** R=3, `req`=0001, `signal_in`=0001 → `grant`=0001 one cycle after E0; `done[0]` in cycle 5 after E0; `signal_out`=0001; `busy` high for 5 cycles.
- **Round robin:** all four `req` held, `signal_in`=1010 → `grant` order 0,1,2,3,0 with period 6 cycles; `signal_out`=1010 after four `done` pulses.
- **Sample point:** `signal_in[1]` toggles 0→1 in the cycle after LOAD → `signal_out[1]`=0 after `done[1]`; a second request yields 1.
- **Dropped request:** `req[2]` deasserted during WAIT → `done[2]` still pulses; next grant goes to the next requester in order.
- **Reset mid-WAIT:** `SystemRst_n` low for 1 cycle → outputs 0 asynchronously; no `done`; after release, a pending `req[3]` is granted with `ptr`=0 priority.
- **Wraparound:** `NUM_REQ`=3, R=1, `req`=101 → grant 0, then 2, then 0; period 4 cycles.
